// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - byte-serial mode-0 SPI master with held chip select
module spi_shift_engine #(
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       IORST_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       cs_assert,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       SPI_CLK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO,
    output logic       SPI_CS_n
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1 || CLK_DIV > 15) begin : g_bad_div
            $error("spi_shift_engine: CLK_DIV must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      tx_sr_q, tx_sr_d;
    logic [7:0]      rx_sr_q, rx_sr_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            cs_n_q, cs_n_d;

    logic            phase_end;
    logic [7:0]      tx_next;
    logic [7:0]      rx_shifted;

    always_comb begin
        phase_end  = (div_cnt_q == DIV_LAST);
        tx_next    = MSB_FIRST ? {tx_sr_q[6:0], 1'b0} : {1'b0, tx_sr_q[7:1]};
        rx_shifted = MSB_FIRST ? {rx_sr_q[6:0], SPI_MISO} : {SPI_MISO, rx_sr_q[7:1]};

        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_sr_d   = tx_data;
                    rx_sr_d   = 8'h00;
                    bit_cnt_d = 3'd0;
                    div_cnt_d = '0;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    mosi_d    = MSB_FIRST ? tx_data[7] : tx_data[0];
                    state_d   = ST_SETUP;
                end else begin
                    cs_n_d = ~cs_assert;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    rx_sr_d   = rx_shifted;
                    state_d   = ST_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b0;
                    state_d   = ST_LOW;
                    // MOSI changes on the falling edge so the slave sees it stable at the next rise
                    if (bit_cnt_q != 3'd7) begin
                        tx_sr_d = tx_next;
                        mosi_d  = MSB_FIRST ? tx_next[7] : tx_next[0];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        sclk_d    = 1'b1;
                        rx_sr_d   = rx_shifted;
                        state_d   = ST_HIGH;
                    end else begin
                        rx_data_d = rx_sr_q;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!IORST_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            tx_sr_q   <= 8'h00;
            rx_sr_q   <= 8'h00;
            rx_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign SPI_CLK  = sclk_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_CS_n = cs_n_q;

endmodule
